// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH clock cycles, LSB first.
//
// state | meaning
// IDLE  | waiting for Start; last result held on Sum/Carry_out
// ADD   | one operand bit pair added per clock
// DONE  | result presented, Done pulses for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
);

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice (WIDTH >= 2).
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    bit_cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] psum_next;

  // Full-adder cell on the current operand LSBs and the running carry.
  always_comb begin
    fa_sum    = op_a[0] ^ op_b[0] ^ carry;
    fa_carry  = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    psum_next = {fa_sum, psum[WIDTH-1:1]};
  end

  // Sequencer, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      psum      <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Sum       <= '0;
      Carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_a    <= A;
            op_b    <= B;
            carry   <= Carry_in;
            psum    <= '0;
            bit_cnt <= '0;
            Busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_carry;
          psum  <= psum_next;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            // Last bit: publish the finished word on the same edge that enters DONE.
            Sum       <= psum_next;
            Carry_out <= fa_carry;
            Done      <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit instance against a timestamp-based reference
// model checked every cycle, plus directed cases and a 4-bit exhaustive sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, co;
  logic [7:0] sum;

  logic       s4, c4;
  logic [3:0] a4, b4;
  logic       busy4, done4, co4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .Start(start), .A(a), .B(b), .Carry_in(cin),
    .Busy(busy), .Done(done), .Sum(sum), .Carry_out(co)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .Start(s4), .A(a4), .B(b4), .Carry_in(c4),
    .Busy(busy4), .Done(done4), .Sum(sum4), .Carry_out(co4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an addition accepted on edge n completes on edge n+8,
  // and the adder is free again for a Start sampled on edge n+10.
  int       m_e;
  int       m_acc;
  bit       m_idle_before;
  bit [8:0] m_pend;
  bit [8:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e   = 0;
      m_acc = -1;
      m_res = '0;
    end else begin
      m_e++;
      m_idle_before = (m_acc < 0);
      if (!m_idle_before && m_e == m_acc + 8) m_res = m_pend;
      if (!m_idle_before && m_e == m_acc + 9) m_acc = -1;
      if (m_idle_before && start === 1'b1) begin
        m_acc  = m_e;
        m_pend = 9'(a) + 9'(b) + 9'(cin);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, 32'(m_acc >= 0));
      chk("done", done, 32'(m_acc >= 0 && m_e == m_acc + 8));
      chk("sum", sum, 32'(m_res[7:0]));
      chk("carry_out", co, 32'(m_res[8]));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b0) return;
      @(posedge clk); #2;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic run8(input string name, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec);
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        chk({name, "_done_early"}, done, 0);
      end else begin
        chk({name, "_done"}, done, 1);
        chk({name, "_sum"}, sum, 32'(es));
        chk({name, "_cout"}, co, 32'(ec));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_cout", co, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum4", sum4, 0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    run8("add_1_1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    run8("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("add_a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Start held high with changing operands through ADD and DONE.
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(posedge clk); #2;
    a = 8'hF0; b = 8'h20; cin = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin
        chk("hold_done", done, 1);
        chk("hold_sum", sum, 32'h33);
        chk("hold_cout", co, 0);
      end
      if (i == 9) begin
        chk("hold_done_single", done, 0);
        chk("hold_busy_idle", busy, 0);
      end
      if (i == 10) begin
        chk("hold_second_start", busy, 1);
        #1 start = 1'b0;
      end
      if (i == 18) begin
        chk("second_done", done, 1);
        chk("second_sum", sum, 32'h11);
        chk("second_cout", co, 1);
      end
    end

    // Reset three cycles into an addition.
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", co, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Previous result must hold during the next addition.
    wait_idle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        chk("hold_prev_sum", sum, 32'h30);
        chk("hold_prev_cout", co, 0);
      end else begin
        chk("next_sum", sum, 32'h80);
        chk("next_done", done, 1);
      end
    end

    // Randomized traffic; operands go X in idle cycles with Start low.
    wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      if (start || $urandom_range(0, 1) == 0) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else begin
        a = 'x; b = 'x; cin = 1'bx;
      end
    end
    @(posedge clk); #2;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    wait_idle();

    // Exhaustive sweep on the 4-bit instance.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          @(posedge clk); #2;
          s4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); c4 = 1'(cv);
          @(posedge clk); #2;
          s4 = 1'b0;
          for (lat = 1; lat <= 12; lat++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) break;
          end
          chk("w4_latency", 32'(lat), 4);
          chk("w4_result", {27'b0, co4, sum4}, 32'(av + bv + cv));
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
